instruction_fetch: RTL

Instruction fetch stage directly upstream of the single-cycle datapath. Owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel. Buffers returned words, each tagged with its PC, in a small queue and hands them to the datapath through a valid/ready handshake. The datapath's taken branches and jumps arrive as a redirect, which flushes the queue and discards responses still in flight.

---
 rtl/instruction_fetch_pkg.sv | 9 +
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/instruction_fetch_fifo.sv | 35 +++
 rtl/instruction_fetch.sv | 60 ++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch-stage constants, state encoding and PC helper
package instruction_fetch_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int FETCH_DEPTH = 4;
  typedef enum logic {FETCH_RUN, FETCH_FLUSH} fetchState_t;
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem request/response, redirect and instruction handshakes of the fetch stage
interface instruction_fetch_if;
  logic imem_req_valid;
  logic imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: synchronous power-of-two FIFO with push, pop and clear; head is read combinationally
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       pushData,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  assign head = mem[rdPtr];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(push);
      rdPtr <= rdPtr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clock)
    if (push && !clear) mem[wrPtr] <= pushData;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: credit-gated in-order imem fetch with a PC-tagged instruction queue and redirect flush
module instruction_fetch import instruction_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int DEPTH = FETCH_DEPTH
) (
  input logic clock,
  input logic reset_n,
  instruction_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetchState_t state, stateNext;
  logic live;
  logic [31:0] fetchPc, reqPcHead;
  logic [63:0] head;
  logic [CW-1:0] outstanding, drop, count, reqCount, newDrop;
  logic reqFire, rspKeep, popFire, redirect;
  assign redirect = bus.redirect_valid;
  assign bus.imem_req_valid = live && state == FETCH_RUN && (outstanding + count) < CW'(DEPTH);
  assign bus.imem_req_addr = fetchPc;
  assign reqFire = bus.imem_req_valid && bus.imem_req_ready;
  assign rspKeep = bus.imem_rsp_valid && state == FETCH_RUN && !redirect;
  assign bus.inst_valid = count != '0;
  assign popFire = bus.inst_valid && bus.inst_ready;
  assign {bus.inst_pc, bus.inst_data} = bus.inst_valid ? head : '0;
  // In RUN drop is 0, in FLUSH outstanding is 0, so the sum is always the in-flight total
  assign newDrop = drop + outstanding + CW'(reqFire) - CW'(bus.imem_rsp_valid);
  always_comb begin
    stateNext = state;
    stateNext = redirect ? (newDrop != '0 ? FETCH_FLUSH : FETCH_RUN)
              : (state == FETCH_FLUSH && bus.imem_rsp_valid && drop == CW'(1)) ? FETCH_RUN : state;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH_RUN;
      live <= 1'b0;
      fetchPc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      state <= stateNext;
      live <= 1'b1;
      fetchPc <= redirect ? alignPc(bus.redirect_pc) : reqFire ? fetchPc + 32'd4 : fetchPc;
      outstanding <= redirect ? '0 : outstanding + CW'(reqFire) - CW'(rspKeep);
      drop <= redirect ? newDrop : (state == FETCH_FLUSH && bus.imem_rsp_valid) ? drop - CW'(1) : drop;
    end
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) reqFifo (
    .clock(clock), .reset_n(reset_n), .clear(redirect), .push(reqFire), .pop(rspKeep),
    .pushData(fetchPc), .head(reqPcHead), .count(reqCount)
  );
  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) dataFifo (
    .clock(clock), .reset_n(reset_n), .clear(redirect), .push(rspKeep), .pop(popFire),
    .pushData({reqPcHead, bus.imem_rsp_data}), .head(head), .count(count)
  );
  always @(posedge clock)
    if (reset_n) begin
      assert (!(rspKeep && count == CW'(DEPTH) && !popFire)) else $error("imem response into full fetch queue");
      assert (!(rspKeep && outstanding == '0)) else $error("imem response with no request outstanding");
      assert (reqCount == outstanding) else $error("request-PC FIFO out of step with outstanding count");
    end
endmodule
